// File: rtl/frame_writer_pkg.sv
// Shared raster geometry macros and FSM state type for the frame writer slice.
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 320
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 240
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 17
`endif
`ifndef H_BITS
`define H_BITS 9
`endif
`ifndef V_BITS
`define V_BITS 8
`endif

package frame_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_WAIT_SYNC,
    ST_SWAP
  } state_t;

  // Animated bring-up colour: raster XOR pattern shifted by the frame number.
  function automatic logic [3:0] pattern_color(input logic [3:0] h,
                                               input logic [3:0] v,
                                               input logic [3:0] f);
    return h ^ v ^ f;
  endfunction

endpackage

// File: rtl/frame_writer_if.sv
// Request/response/write-port bundle between the frame writer, the ray marcher and the framebuffer manager.
interface frame_writer_if #(
  parameter int ADDR_LEN = `ADDR_BITS,
  parameter int WIDTH    = 4
);
  logic                req_valid_out;
  logic                req_ready_in;
  logic [`H_BITS-1:0]  req_hcount_out;
  logic [`V_BITS-1:0]  req_vcount_out;
  logic [ADDR_LEN-1:0] req_addr_out;
  logic                resp_valid_in;
  logic                resp_ready_out;
  logic [ADDR_LEN-1:0] resp_addr_in;
  logic [WIDTH-1:0]    resp_color_in;
  logic                write_enable_out;
  logic [ADDR_LEN-1:0] write_addr_out;
  logic [WIDTH-1:0]    write_data_out;

  modport master (
    output req_valid_out, req_hcount_out, req_vcount_out, req_addr_out,
    output resp_ready_out, write_enable_out, write_addr_out, write_data_out,
    input  req_ready_in, resp_valid_in, resp_addr_in, resp_color_in
  );

  modport slave (
    input  req_valid_out, req_hcount_out, req_vcount_out, req_addr_out,
    input  resp_ready_out, write_enable_out, write_addr_out, write_data_out,
    output req_ready_in, resp_valid_in, resp_addr_in, resp_color_in
  );
endinterface

// File: rtl/frame_writer_raster_counter.sv
// Raster walker: column/row counters with linear address, wrapping to pixel 0 after the last pixel.
module raster_counter #(
  parameter int DISPLAY_WIDTH  = `DISPLAY_WIDTH,
  parameter int DISPLAY_HEIGHT = `DISPLAY_HEIGHT,
  parameter int ADDR_LEN       = `ADDR_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clear,
  input  logic                i_advance,
  output logic [`H_BITS-1:0]  o_hcount,
  output logic [`V_BITS-1:0]  o_vcount,
  output logic [ADDR_LEN-1:0] o_addr,
  output logic                o_last
);
  localparam logic [`H_BITS-1:0]  H_LAST   = `H_BITS'(DISPLAY_WIDTH - 1);
  localparam logic [`V_BITS-1:0]  V_LAST   = `V_BITS'(DISPLAY_HEIGHT - 1);
  localparam logic [ADDR_LEN-1:0] LINE_LEN = ADDR_LEN'(DISPLAY_WIDTH);

  logic [`H_BITS-1:0] r_hcount;
  logic [`V_BITS-1:0] r_vcount;
  logic               w_h_last;

  assign w_h_last = (r_hcount == H_LAST);
  assign o_last   = w_h_last && (r_vcount == V_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (i_clear) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (i_advance) begin
      if (w_h_last) begin
        r_hcount <= '0;
        r_vcount <= (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
      end else begin
        r_hcount <= r_hcount + 1'b1;
      end
    end
  end

  assign o_hcount = r_hcount;
  assign o_vcount = r_vcount;
  // Product kept at address width so the frame address never overflows into garbage bits.
  assign o_addr   = ADDR_LEN'(r_vcount) * LINE_LEN + ADDR_LEN'(r_hcount);

endmodule

// File: rtl/frame_writer.sv
// Frame writer: issues raster pixel requests, writes returned colours to the back buffer, swaps on vsync.
// Define FRAME_WRITER_TEST_PATTERN_EN to replace the ray-marcher handshake with an internal XOR test pattern.
module frame_writer
  import frame_writer_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = `DISPLAY_WIDTH,
  parameter int DISPLAY_HEIGHT = `DISPLAY_HEIGHT,
  parameter int ADDR_LEN       = `ADDR_BITS,
  parameter int WIDTH          = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vsync_in,
  frame_writer_if.master       bus,
  output logic                 swap_buffers_out,
  output logic [15:0]          frame_count_out
);
  localparam int              WC_W      = ADDR_LEN + 1;
  localparam logic [WC_W-1:0] PIX_TOTAL = WC_W'(DISPLAY_WIDTH * DISPLAY_HEIGHT);

  state_t              r_state, w_state_nxt;
  logic                r_vsync_prev;
  logic [WC_W-1:0]     r_written;
  logic [15:0]         r_frame_count;
  logic                r_wr_en_p1;
  logic [ADDR_LEN-1:0] r_wr_addr_p1;
  logic [WIDTH-1:0]    r_wr_data_p1;

  logic                w_issuing, w_advance, w_last, w_clear, w_vsync_edge;
  logic                w_req_valid, w_resp_ready, w_swap;
  logic [`H_BITS-1:0]  w_hcount;
  logic [`V_BITS-1:0]  w_vcount;
  logic [ADDR_LEN-1:0] w_addr;

  assign w_issuing    = (r_state == ST_ISSUE);
  assign w_clear      = (r_state == ST_SWAP);
  assign w_vsync_edge = vsync_in && !r_vsync_prev;

`ifdef FRAME_WRITER_TEST_PATTERN_EN
  assign w_advance = w_issuing;
`else
  assign w_advance = w_issuing && bus.req_ready_in;
`endif

  raster_counter #(
    .DISPLAY_WIDTH (DISPLAY_WIDTH),
    .DISPLAY_HEIGHT(DISPLAY_HEIGHT),
    .ADDR_LEN      (ADDR_LEN)
  ) u_raster (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_advance(w_advance),
    .o_hcount (w_hcount),
    .o_vcount (w_vcount),
    .o_addr   (w_addr),
    .o_last   (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_req_valid  = 1'b0;
    w_resp_ready = 1'b0;
    w_swap       = 1'b0;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        w_req_valid  = 1'b1;
        w_resp_ready = 1'b1;
        if (w_advance && w_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_resp_ready = 1'b1;
        if (r_written == PIX_TOTAL) w_state_nxt = ST_WAIT_SYNC;
      end
      // Edges that arrive before this state (even with the last write) are deliberately missed.
      ST_WAIT_SYNC: if (w_vsync_edge) w_state_nxt = ST_SWAP;
      ST_SWAP: begin
        w_swap      = 1'b1;
        w_state_nxt = ST_ISSUE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---- write stage p1: one cycle after acceptance / raster step ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en_p1   <= 1'b0;
      r_wr_addr_p1 <= '0;
      r_wr_data_p1 <= '0;
    end else begin
`ifdef FRAME_WRITER_TEST_PATTERN_EN
      r_wr_en_p1 <= w_advance;
      if (w_advance) begin
        r_wr_addr_p1 <= w_addr;
        r_wr_data_p1 <= WIDTH'(pattern_color(w_hcount[3:0], w_vcount[3:0],
                                             r_frame_count[3:0]));
      end
`else
      r_wr_en_p1 <= w_resp_ready && bus.resp_valid_in;
      if (w_resp_ready && bus.resp_valid_in) begin
        r_wr_addr_p1 <= bus.resp_addr_in;
        r_wr_data_p1 <= bus.resp_color_in;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_written     <= '0;
      r_frame_count <= '0;
      r_vsync_prev  <= 1'b0;
    end else begin
      r_vsync_prev <= vsync_in;
      if (w_clear)         r_written <= '0;
      else if (r_wr_en_p1) r_written <= r_written + 1'b1;
      if (w_swap) r_frame_count <= r_frame_count + 1'b1;
    end
  end

`ifdef FRAME_WRITER_TEST_PATTERN_EN
  assign bus.req_valid_out  = 1'b0;
  assign bus.req_hcount_out = '0;
  assign bus.req_vcount_out = '0;
  assign bus.req_addr_out   = '0;
  assign bus.resp_ready_out = 1'b0;
`else
  assign bus.req_valid_out  = w_req_valid;
  assign bus.req_hcount_out = w_hcount;
  assign bus.req_vcount_out = w_vcount;
  assign bus.req_addr_out   = w_addr;
  assign bus.resp_ready_out = w_resp_ready;
`endif
  assign bus.write_enable_out = r_wr_en_p1;
  assign bus.write_addr_out   = r_wr_addr_p1;
  assign bus.write_data_out   = r_wr_data_p1;
  assign swap_buffers_out     = w_swap;
  assign frame_count_out      = r_frame_count;

endmodule
